// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Time-shares one single-cycle combinational ALU between two
//                independent requesters. Operations are accepted over
//                valid/ready, one grant per cycle, the granted operands are
//                registered onto the ALU inputs, and the ALU result is
//                captured the following cycle into a one-entry response
//                buffer owned by the issuing requester.
//
//                Arbitration is round-robin. Defining ALU_ARB_FIXED_PRIO_EN
//                selects fixed priority (req0 wins) and removes the
//                last-grant register.
//
//  Ports       : clk, rst (async, active-high)
//                reqN_valid/ready/op1/op2/ctrl  - operation request, N=0,1
//                alu_op1/op2/ctrl               - registered ALU inputs
//                alu_out/alu_eq                 - ALU result and branch flag
//                rspN_valid/ready/data/eq       - buffered response, N=0,1
//
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_op1,
    input  logic [DATA_WIDTH-1:0] req0_op2,
    input  logic [3:0]            req0_ctrl,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_op1,
    input  logic [DATA_WIDTH-1:0] req1_op2,
    input  logic [3:0]            req1_ctrl,

    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    output logic [3:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_eq,

    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    output logic                  rsp0_eq,

    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic                  rsp1_eq
);

    // Issue stage state. The ALU operand registers double as the issue
    // operand registers: they are loaded on a handshake and zeroed otherwise,
    // so alu_* are 0 whenever r_issue_valid is 0.
    logic r_run;          // goes high one cycle after reset release
    logic r_issue_valid;
    logic r_issue_id;

    logic w_elig0;
    logic w_elig1;
    logic w_cand0;
    logic w_cand1;
    logic w_gnt;
    logic w_hs;

    // A requester is eligible only if it has nothing in the ALU and its
    // response buffer will be free (or drained) by the time its result lands.
    assign w_elig0 = !(r_issue_valid && (r_issue_id == 1'b0)) && (!rsp0_valid || rsp0_ready);
    assign w_elig1 = !(r_issue_valid && (r_issue_id == 1'b1)) && (!rsp1_valid || rsp1_ready);

    assign w_cand0 = req0_valid && w_elig0;
    assign w_cand1 = req1_valid && w_elig1;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: req0 wins whenever it can be served.
    always_comb begin
        w_gnt = 1'b0;
        if (!w_cand0 && w_cand1) begin
            w_gnt = 1'b1;
        end
    end
`else
    logic r_last_gnt;

    // Round-robin: on contention, grant the requester not served last.
    always_comb begin
        w_gnt = 1'b0;
        if (w_cand0 && w_cand1) begin
            w_gnt = ~r_last_gnt;
        end else if (w_cand1) begin
            w_gnt = 1'b1;
        end
    end

    // Reset value 1 makes req0 win the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_gnt <= 1'b1;
        end else if (w_hs) begin
            r_last_gnt <= w_gnt;
        end
    end
`endif

    // r_run keeps ready low through reset and for the cycle in which reset
    // is released.
    assign req0_ready = r_run && w_elig0 && (w_gnt == 1'b0);
    assign req1_ready = r_run && w_elig1 && (w_gnt == 1'b1);

    // Grant is one-hot, so at most one of these handshakes fires.
    assign w_hs = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run         <= 1'b0;
            r_issue_valid <= 1'b0;
            r_issue_id    <= 1'b0;
            alu_op1       <= '0;
            alu_op2       <= '0;
            alu_ctrl      <= '0;
        end else begin
            r_run         <= 1'b1;
            r_issue_valid <= w_hs;
            if (w_hs) begin
                r_issue_id <= w_gnt;
                alu_op1    <= w_gnt ? req1_op1  : req0_op1;
                alu_op2    <= w_gnt ? req1_op2  : req0_op2;
                alu_ctrl   <= w_gnt ? req1_ctrl : req0_ctrl;
            end else begin
                alu_op1    <= '0;
                alu_op2    <= '0;
                alu_ctrl   <= '0;
            end
        end
    end

    // Completion: the ALU result is always captured the cycle after issue.
    // A completion takes precedence over a pop, so a same-cycle pop and
    // refill leaves valid set with the new data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_eq    <= 1'b0;
        end else if (r_issue_valid && (r_issue_id == 1'b0)) begin
            rsp0_valid <= 1'b1;
            rsp0_data  <= alu_out;
            rsp0_eq    <= alu_eq;
        end else if (rsp0_ready) begin
            rsp0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_eq    <= 1'b0;
        end else if (r_issue_valid && (r_issue_id == 1'b1)) begin
            rsp1_valid <= 1'b1;
            rsp1_data  <= alu_out;
            rsp1_eq    <= alu_eq;
        end else if (rsp1_ready) begin
            rsp1_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_arbiter
//  Description : Directed-vector bench for alu_share_arbiter. Supplies a
//                small RV32-style ALU model on the alu_* side and checks
//                grants, latency, response data and reset behaviour against
//                hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [3:0]    req0_ctrl, req1_ctrl;
    logic [DW-1:0] alu_op1, alu_op2, alu_out;
    logic [3:0]    alu_ctrl;
    logic          alu_eq;
    logic          rsp0_valid, rsp0_ready, rsp0_eq;
    logic          rsp1_valid, rsp1_ready, rsp1_eq;
    logic [DW-1:0] rsp0_data, rsp1_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op1   (req0_op1),
        .req0_op2   (req0_op2),
        .req0_ctrl  (req0_ctrl),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op1   (req1_op1),
        .req1_op2   (req1_op2),
        .req1_ctrl  (req1_ctrl),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_ctrl   (alu_ctrl),
        .alu_out    (alu_out),
        .alu_eq     (alu_eq),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp0_eq    (rsp0_eq),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rsp1_eq    (rsp1_eq)
    );

    // External ALU: ctrl = {func7[5], func3}; eq follows the branch func3.
    always_comb begin
        alu_out = '0;
        alu_eq  = 1'b0;
        case (alu_ctrl)
            4'b0000: alu_out = alu_op1 + alu_op2;
            4'b1000: alu_out = alu_op1 - alu_op2;
            4'b0001: alu_out = alu_op1 << alu_op2[4:0];
            4'b0101: alu_out = alu_op1 >> alu_op2[4:0];
            4'b1101: alu_out = $unsigned($signed(alu_op1) >>> alu_op2[4:0]);
            4'b0100: alu_out = alu_op1 ^ alu_op2;
            4'b0110: alu_out = alu_op1 | alu_op2;
            4'b0111: alu_out = alu_op1 & alu_op2;
            default: alu_out = alu_op1 + alu_op2;
        endcase
        case (alu_ctrl[2:0])
            3'b000:  alu_eq = (alu_op1 == alu_op2);
            3'b001:  alu_eq = (alu_op1 != alu_op2);
            3'b100:  alu_eq = ($signed(alu_op1) <  $signed(alu_op2));
            3'b101:  alu_eq = ($signed(alu_op1) >= $signed(alu_op2));
            3'b110:  alu_eq = (alu_op1 <  alu_op2);
            3'b111:  alu_eq = (alu_op1 >= alu_op2);
            default: alu_eq = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        req0_valid = v; req0_op1 = a; req0_op2 = b; req0_ctrl = c;
    endtask

    task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        req1_valid = v; req1_op1 = a; req1_op2 = b; req1_ctrl = c;
    endtask

    logic [1:0] exp_gnt;

    initial begin
        rst = 1'b1;
        set_req0(1'b0, 32'd0, 32'd0, 4'd0);
        set_req1(1'b0, 32'd0, 32'd0, 4'd0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;

        // ---- reset state ----
        step();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rst_rdy0",   32'(req0_ready), 32'd0);
        chk("rst_rdy1",   32'(req1_ready), 32'd0);
        chk("rst_rsp0v",  32'(rsp0_valid), 32'd0);
        chk("rst_rsp0d",  rsp0_data,       32'd0);
        chk("rst_rsp1v",  32'(rsp1_valid), 32'd0);
        chk("rst_aluop1", alu_op1,         32'd0);
        chk("rst_aluctl", 32'(alu_ctrl),   32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        rst = 1'b0;
        step();

        // ---- ADD on req0: handshake c0, ALU c1, response c2 ----
        set_req0(1'b1, 32'd5, 32'd7, 4'b0000);
        #1;
        chk("add_rdy",    32'(req0_ready), 32'd1);
        chk("add_alu_c0", alu_op1,         32'd0);
        step();
        req0_valid = 1'b0;
        #1;
        chk("add_alu1_c1", alu_op1,         32'd5);
        chk("add_alu2_c1", alu_op2,         32'd7);
        chk("add_rspv_c1", 32'(rsp0_valid), 32'd0);
        step();
        chk("add_rspv",   32'(rsp0_valid), 32'd1);
        chk("add_data",   rsp0_data,       32'd12);
        chk("add_eq",     32'(rsp0_eq),    32'd0);
        chk("add_alu_c2", alu_op1,         32'd0);
        step();
        chk("add_pop",    32'(rsp0_valid), 32'd0);

        // ---- SUB then SRA on req1, in order ----
        set_req1(1'b1, 32'd3, 32'd5, 4'b1000);
        #1;
        chk("sub_rdy", 32'(req1_ready), 32'd1);
        step();
        set_req1(1'b1, 32'h8000_0000, 32'd4, 4'b1101);
        #1;
        chk("sra_blk", 32'(req1_ready), 32'd0);
        step();
        chk("sub_rspv", 32'(rsp1_valid), 32'd1);
        chk("sub_data", rsp1_data,       32'hFFFF_FFFE);
        chk("sra_rdy",  32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        #1;
        chk("sra_gap",  32'(rsp1_valid), 32'd0);
        step();
        chk("sra_rspv", 32'(rsp1_valid), 32'd1);
        chk("sra_data", rsp1_data,       32'hF800_0000);
        step();

        // ---- contention: 8 cycles, alternating grants starting at req0 ----
        for (int k = 0; k < 8; k++) begin
            set_req0(1'b1, 32'(k), 32'h100, 4'b0000);
            set_req1(1'b1, 32'(k), 32'h200, 4'b0000);
            #1;
            exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("cont_gnt", 32'({req1_ready, req0_ready}), 32'(exp_gnt));
            if (k >= 2 && (k % 2 == 0)) chk("cont_rsp0", rsp0_data, 32'(k - 2) + 32'h100);
            if (k >= 3 && (k % 2 == 1)) chk("cont_rsp1", rsp1_data, 32'(k - 2) + 32'h200);
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        step();

        // ---- last grant was req0: round-robin now prefers req1 ----
        req0_valid = 1'b1;
        #1;
        chk("rr_solo", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        step();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        chk("rr_pick", 32'({req1_ready, req0_ready}), 32'd1);
`else
        chk("rr_pick", 32'({req1_ready, req0_ready}), 32'd2);
`endif
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) step();

        // ---- backpressure on rsp0 ----
        rsp0_ready = 1'b0;
        set_req0(1'b1, 32'h11, 32'h22, 4'b0000);
        #1;
        chk("bp_rdy0_c0", 32'(req0_ready), 32'd1);
        step();
        set_req0(1'b1, 32'h55, 32'h66, 4'b0000);
        set_req1(1'b1, 32'd1, 32'd1, 4'b0000);
        #1;
        chk("bp_rdy0_c1", 32'(req0_ready), 32'd0);
        chk("bp_rdy1_c1", 32'(req1_ready), 32'd1);
        step();
        chk("bp_rspv_c2", 32'(rsp0_valid), 32'd1);
        chk("bp_data_c2", rsp0_data,       32'h33);
        chk("bp_rdy0_c2", 32'(req0_ready), 32'd0);
        chk("bp_rdy1_c2", 32'(req1_ready), 32'd0);
        step();
        chk("bp_rdy0_c3", 32'(req0_ready), 32'd0);
        chk("bp_rdy1_c3", 32'(req1_ready), 32'd1);
        chk("bp_data_c3", rsp0_data,       32'h33);
        step();
        chk("bp_rdy0_c4", 32'(req0_ready), 32'd0);
        chk("bp_rdy1_c4", 32'(req1_ready), 32'd0);
        chk("bp_data_c4", rsp0_data,       32'h33);
        step();
        rsp0_ready = 1'b1;
        #1;
        chk("bp_reen0", 32'(req0_ready), 32'd1);
        chk("bp_reen1", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("bp_gap",  32'(rsp0_valid), 32'd0);
        step();
        chk("bp_new",  rsp0_data,       32'hBB);
        step();
        step();

        // ---- branch flag ----
        set_req0(1'b1, 32'h10, 32'h10, 4'b0000);
        #1;
        chk("br_rdy_a", 32'(req0_ready), 32'd1);
        step();
        set_req0(1'b1, 32'd2, 32'd3, 4'b0111);
        step();
        chk("br_eq_beq", 32'(rsp0_eq),    32'd1);
        chk("br_rdy_b",  32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        step();
        chk("br_rspv",   32'(rsp0_valid), 32'd1);
        chk("br_eq_bgeu", 32'(rsp0_eq),   32'd0);
        step();
        step();

        // ---- reset with an op in flight ----
        set_req0(1'b1, 32'd1, 32'd1, 4'b0000);
        #1;
        chk("mr_rdy", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mr_rspv_a", 32'(rsp0_valid), 32'd0);
        chk("mr_alu",    alu_op1,         32'd0);
        step();
        rst = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("mr_rspv_b", 32'(rsp0_valid), 32'd0);
        chk("mr_rdy_rel", 32'({req1_ready, req0_ready}), 32'd0);
        step();
        chk("mr_rspv_c", 32'(rsp0_valid), 32'd0);
        chk("mr_gnt",    32'({req1_ready, req0_ready}), 32'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter that time-shares the single-cycle combinational ALU between independent issue sources, e.g. the execute stage and a branch-resolution/AGU path. It accepts operations over valid/ready handshakes, grants one per cycle, registers the operands that drive the ALU, and captures each result into a one-entry response buffer for the requester that issued it. Arbitration is round-robin by default. A compile-time option selects fixed priority instead.

## Interface
- DATA_WIDTH, 32, operand/result width; must equal the ALU width.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- reqN_valid  in  1  requester N (N=0,1) presents an operation.
- reqN_ready  out  1  operation accepted this cycle when valid&ready.
- reqN_op1 / reqN_op2  in  DATA_WIDTH  operands.
- reqN_ctrl  in  4  ALU control {func7[5], func3[2:0]}.
- alu_op1 / alu_op2  out  DATA_WIDTH  registered operands to ALU.
- alu_ctrl  out  4  registered control to ALU.
- alu_out  in  DATA_WIDTH  ALU result (combinational from alu_* outputs).
- alu_eq  in  1  ALU branch-condition flag.
- rspN_valid  out  1  result buffered for requester N.
- rspN_ready  in  1  requester N consumes result.
- rspN_data  out  DATA_WIDTH  buffered alu_out.
- rspN_eq  out  1  buffered alu_eq.

## Operation
- Issue stage: issue_valid, issue_id, issue_op1/op2/ctrl registers.
  - alu_op1/op2/ctrl equal the issue registers when issue_valid=1; they are forced to 0 when issue_valid=0.
- eligible_N = !(issue_valid && issue_id==N) && (!rspN_valid || rspN_ready). At most one operation is outstanding per requester.
- Grant is combinational from valid and eligibility.
  - Round-robin: last_gnt register. If both requesters are valid and eligible, grant the one not equal to last_gnt. If only one is, grant it.
  - last_gnt updates to the granted id only on a handshake.
- reqN_ready = eligible_N && grant==N. reqN_ready may depend on both reqX_valid. Requesters must not make valid depend on ready.
- On handshake: load the issue registers from the granted requester and set issue_valid=1.
- With no handshake, issue_valid=0 next cycle. There is no stall: the ALU result is always captured the cycle after issue.
- Completion: when issue_valid=1, rsp[issue_id] loads alu_out/alu_eq and rspN_valid=1.
- rspN_valid clears on rspN_ready when no completion lands the same cycle.
- rspN_data/eq hold stable while rspN_valid && !rspN_ready.
- A simultaneous pop and completion for the same N is legal only via the eligibility rule. In that case the new data replaces the old and valid stays 1.
- Reset values: all rspN_valid=0, rspN_data=0, rspN_eq=0, issue_valid=0, alu_*=0, last_gnt=1 (req0 wins first contention).
- Reset mid-operation: the in-flight operation and buffered results are discarded. No response is produced for them.

## Timing
- Latency: handshake in cycle T, ALU driven in cycle T+1, rspN_valid=1 in cycle T+2.
- Aggregate throughput is 1 op/cycle when requesters alternate. Per-requester throughput is 1 op/2 cycles.
- A held rspN_ready=0 blocks requester N only. The other requester continues at full rate.
- reqN_ready is 0 throughout reset and returns the cycle after rst deasserts.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: req0 always wins when both requesters are valid and eligible. last_gnt is not implemented.
  - req1 can starve under continuous req0 traffic; this is accepted.
- Undefined (default): round-robin as above.
  - Under continuous contention with both rsp_ready=1, each requester is granted at least once every 2 grants.

## Test plan
- ADD: req0 op1=5, op2=7, ctrl=0000 accepted in cycle 0 -> rsp0_valid in cycle 2, rsp0_data=12, rsp0_eq=0. alu_* are 0 in cycles 0 and 2.
- SUB/SRA: req1 3-5 (ctrl 1000) -> 0xFFFFFFFE. req1 0x80000000 >>> 4 (ctrl 1101) -> 0xF8000000. Responses arrive in order.
- Contention: both valid, both rsp_ready=1, for 8 cycles -> grant sequence 0,1,0,1,… starting at req0.
  - With ALU_ARB_FIXED_PRIO_EN: req0 on every eligible cycle, req1 only in req0's ineligible cycles.
- Backpressure: rsp0_ready=0 with rsp0_valid=1 -> req0_ready=0 and rsp0_data stable. req1 issues every other cycle. Raising rsp0_ready re-enables req0 the same cycle.
- Branch flag: req0 op1=op2=0x10, ctrl=0000 -> rsp0_eq=1. ctrl=0111 (BGEU) with 2 vs 3 -> rsp0_eq=0.
- Reset: rst asserted in cycle T+1 of an in-flight op -> rsp0_valid stays 0 and no response appears. After release, the first contention grants req0.
